mux_logic_unit: RTL

//  Parametrised, registered bitwise logic unit. Every result bit is built only from 2:1 mux cells.

---
 rtl/mux_logic_pkg.sv | 49 ++++
 rtl/mux_gate_bit.sv | 32 +++
 rtl/mux_logic_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mux_logic_pkg.sv
// Shared types for the mux-built logic unit: op codes, FSM states and the
// op -> mux input-source mapping used by every result bit.
package mux_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_NAND = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        FOLD = 1'b1
    } state_e;

    // Value routed to one data input of the 2:1 mux
    typedef enum logic [1:0] {
        SRC_ZERO = 2'b00,
        SRC_ONE  = 2'b01,
        SRC_Y    = 2'b10,
        SRC_NY   = 2'b11
    } src_e;

    typedef struct packed {
        src_e i0;
        src_e i1;
    } gate_sel_t;

    function automatic gate_sel_t gate_sel(input op_e op);
        gate_sel_t s;
        case (op)
            OP_AND:  s = '{i0: SRC_ZERO, i1: SRC_Y};
            OP_OR:   s = '{i0: SRC_Y,    i1: SRC_ONE};
            OP_NOT:  s = '{i0: SRC_ONE,  i1: SRC_ZERO};
            OP_NAND: s = '{i0: SRC_ONE,  i1: SRC_NY};
            OP_XOR:  s = '{i0: SRC_Y,    i1: SRC_NY};
            OP_XNOR: s = '{i0: SRC_NY,   i1: SRC_Y};
            OP_NOR:  s = '{i0: SRC_NY,   i1: SRC_ZERO};
            default: s = '{i0: SRC_ZERO, i1: SRC_ONE};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mux_gate_bit.sv
// One result bit of f(op,x,y): a single 2:1 mux with x as select and
// op-dependent constants / y / ~y routed to its data inputs.
module mux_gate_bit
    import mux_logic_pkg::*;
(
    input  op_e  op_i,
    input  logic x_i,
    input  logic y_i,
    output logic o_o
);

    gate_sel_t sel;
    logic      i0;
    logic      i1;

    function automatic logic src_val(input src_e s, input logic yv);
        case (s)
            SRC_ZERO: return 1'b0;
            SRC_ONE:  return 1'b1;
            SRC_Y:    return yv;
            default:  return ~yv;
        endcase
    endfunction

    always_comb begin
        sel = gate_sel(op_i);
        i0  = src_val(sel.i0, y_i);
        i1  = src_val(sel.i1, y_i);
        o_o = x_i ? i1 : i0;
    end

endmodule

// File: rtl/mux_logic_unit.sv
// Registered mux-built logic unit with single and fold modes and a
// single-entry output slot. Optional y_par output under MUX_LOGIC_PARITY_EN.
module mux_logic_unit
    import mux_logic_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned FOLD_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
`ifdef MUX_LOGIC_PARITY_EN
    output logic             y_par,
`endif
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(FOLD_LEN);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               out_valid_q, out_valid_d;

    op_e                g_op;
    logic [WIDTH-1:0]   g_x;
    logic [WIDTH-1:0]   g_y;
    logic [WIDTH-1:0]   g_o;

    logic               slot_free;
    logic               last_beat;
    logic               wr;

    // One gate array shared by both paths: IDLE uses (op,a,b), FOLD uses (op_q,acc,a)
    always_comb begin
        if (state_q == FOLD) begin
            g_op = op_q;
            g_x  = acc_q;
            g_y  = a;
        end else begin
            g_op = op_e'(op);
            g_x  = a;
            g_y  = b;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_gate_bit u_bit (
            .op_i (g_op),
            .x_i  (g_x[i]),
            .y_i  (g_y[i]),
            .o_o  (g_o[i])
        );
    end

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        last_beat = (cnt_q == CNT_W'(FOLD_LEN - 1));
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        op_d      = op_q;
        y_d       = y_q;
        wr        = 1'b0;
        in_ready  = slot_free;

        case (state_q)
            IDLE: begin
                in_ready = slot_free;
                if (in_valid && in_ready) begin
                    if (!mode) begin
                        y_d = g_o;
                        wr  = 1'b1;
                    end else begin
                        acc_d   = g_o;
                        op_d    = op_e'(op);
                        cnt_d   = CNT_W'(1);
                        state_d = FOLD;
                    end
                end
            end
            FOLD: begin
                if (last_beat) begin
                    in_ready = slot_free;
                    if (in_valid && in_ready) begin
                        y_d     = g_o;
                        wr      = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d = g_o;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            op_q        <= OP_AND;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MUX_LOGIC_PARITY_EN
    logic y_par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_par_q <= 1'b0;
        end else if (wr) begin
            y_par_q <= ^g_o;
        end
    end

    assign y_par = y_par_q;
`endif

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == FOLD);

endmodule
